// File: rtl/muldiv_hilo_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Multi-cycle ops run IDLE -> RUN (WIDTH cycles) -> FIX -> DONE behind a busy/done handshake.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [3:0] OP_MFLO  = 4'b1000;
  localparam logic [3:0] OP_MFHI  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_MADDU = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_MTHI  = 4'b0100;
  localparam logic [3:0] OP_MTLO  = 4'b0101;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [3:0]           op_r;
  logic                 sign_a, sign_b, b_zero;

  logic                 multi_op, signed_op, div_op, r_div;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   acc_step, fix_val;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    multi_op  = (op == OP_MULTU) || (op == OP_MADDU) || (op == OP_MULT) ||
                (op == OP_DIV)   || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    div_op    = (op == OP_DIV) || (op == OP_DIVU);
    mag_a     = (signed_op && dataA[WIDTH-1]) ? -dataA : dataA;
    mag_b     = (signed_op && dataB[WIDTH-1]) ? -dataB : dataB;
  end

  // Upper accumulator half is the remainder for divides and the partial product for multiplies.
  always_comb begin
    r_div     = (op_r == OP_DIV) || (op_r == OP_DIVU);
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (r_div) begin
      acc_step = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                  acc[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    quo     = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_val = acc;
    if (r_div) begin
      fix_val = {rem, (b_zero ? {WIDTH{1'b1}} : quo)};
    end else if (op_r == OP_MADDU) begin
      fix_val = {hi, lo} + acc;
    end else if (op_r == OP_MULT && (sign_a ^ sign_b)) begin
      fix_val = -acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && multi_op) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_r   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (op == OP_MTHI) hi <= dataA;
          if (op == OP_MTLO) lo <= dataA;
          if (multi_op) begin
            op_r   <= op;
            cnt    <= '0;
            sign_a <= signed_op && dataA[WIDTH-1];
            sign_b <= signed_op && dataB[WIDTH-1];
            b_zero <= (dataB == '0);
            opnd   <= div_op ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= acc_step;
        end
        FIX: {hi, lo} <= fix_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed, table-driven bench for muldiv_hilo_unit (WIDTH=32) plus hand-written
// sequences for busy-time starts, DONE-cycle starts and mid-operation reset.
module tb_muldiv_hilo_unit;

  localparam logic [3:0] NOP = 4'b0000, MFLO = 4'b1000, MFHI = 4'b1001,
                         MULTU = 4'b1010, MADDU = 4'b1011, MULT = 4'b1100,
                         DIV = 4'b1101, DIVU = 4'b1110, MTHI = 4'b0100, MTLO = 4'b0101;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0]  op = NOP;
  logic [31:0] dataA = '0, dataB = '0;
  logic        busy, done;
  logic [31:0] hi, lo, result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    bit          preload;
    logic [31:0] pre_hi, pre_lo;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[13];

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; op = o; dataA = v;
    @(posedge clk); #1;
    start = 1'b0; op = NOP;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    int done_cyc;
    logic busy1, busy_at_done;
    done_cyc = -1; busy1 = 1'b0; busy_at_done = 1'b1;
    if (v.preload) begin
      write_reg(MTHI, v.pre_hi);
      write_reg(MTLO, v.pre_lo);
    end
    @(negedge clk);
    start = 1'b1; op = v.op; dataA = v.a; dataB = v.b;
    @(posedge clk); #1;
    start = 1'b0; op = NOP; dataA = 32'hA5A5A5A5; dataB = 32'h0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (done) begin
        done_cyc = k;
        busy_at_done = busy;
        break;
      end
    end
    check_output($sformatf("v%0d busy_c1", idx), {31'b0, busy1}, 32'd1);
    check_output($sformatf("v%0d done_cycle", idx), done_cyc, 32'd34);
    check_output($sformatf("v%0d busy_at_done", idx), {31'b0, busy_at_done}, 32'd0);
    check_output($sformatf("v%0d hi", idx), hi, v.exp_hi);
    check_output($sformatf("v%0d lo", idx), lo, v.exp_lo);
    op = MFLO; #1;
    check_output($sformatf("v%0d mflo", idx), result, v.exp_lo);
    op = MFHI; #1;
    check_output($sformatf("v%0d mfhi", idx), result, v.exp_hi);
    op = NOP;
  endtask

  initial begin
    int done_cyc;
    vec_t v;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000005, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 1'b0, 32'h0, 32'h0, 32'h40000000, 32'h00000000};
    vecs[3]  = '{MADDU, 32'h00000001, 32'h00000001, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[4]  = '{MADDU, 32'h00000001, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[5]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6]  = '{DIVU,  32'h00000007, 32'h00000000, 1'b0, 32'h0, 32'h0, 32'h00000007, 32'hFFFFFFFF};
    vecs[7]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'h00000000, 32'h80000000};
    vecs[8]  = '{DIVU,  32'h00000064, 32'h00000007, 1'b0, 32'h0, 32'h0, 32'h00000002, 32'h0000000E};
    vecs[9]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{DIV,   32'hFFFFFFF9, 32'h00000000, 1'b0, 32'h0, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[11] = '{MULTU, 32'h12345678, 32'h00000010, 1'b0, 32'h0, 32'h0, 32'h00000001, 32'h23456780};
    vecs[12] = '{MADDU, 32'h00010000, 32'h00010000, 1'b1, 32'h00000005, 32'h00000003, 32'h00000006, 32'h00000003};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check_output("reset busy", {31'b0, busy}, 32'd0);
    check_output("reset done", {31'b0, done}, 32'd0);
    check_output("reset hi", hi, 32'd0);
    check_output("reset lo", lo, 32'd0);

    for (int i = 0; i < 13; i++) apply_stimulus(vecs[i], i);

    // Starts while busy are ignored; a start during DONE is ignored too.
    write_reg(MTHI, 32'h11111111);
    write_reg(MTLO, 32'h22222222);
    @(negedge clk);
    start = 1'b1; op = MULTU; dataA = 32'hFFFFFFFF; dataB = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0; op = NOP;
    done_cyc = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5)  begin start = 1'b1; op = DIVU; dataA = 32'h9; dataB = 32'h3; end
      if (k == 6)  begin start = 1'b0; op = NOP; end
      if (k == 10) begin start = 1'b1; op = MTHI; dataA = 32'hDEADBEEF; end
      if (k == 11) begin
        start = 1'b0; op = NOP;
        check_output("busy hi hold", hi, 32'h11111111);
        check_output("busy lo hold", lo, 32'h22222222);
      end
      if (done) begin done_cyc = k; break; end
    end
    check_output("seqA done_cycle", done_cyc, 32'd34);
    check_output("seqA hi", hi, 32'hFFFFFFFE);
    check_output("seqA lo", lo, 32'h00000001);
    start = 1'b1; op = MTLO; dataA = 32'h00000055;
    @(posedge clk); #1;
    start = 1'b0; op = NOP;
    @(negedge clk);
    check_output("done-cycle mtlo ignored", lo, 32'h00000001);
    check_output("no restart after done", {31'b0, busy}, 32'd0);

    // Reset in the middle of a divide discards it.
    write_reg(MTHI, 32'h0000AAAA);
    write_reg(MTLO, 32'h0000BBBB);
    @(negedge clk);
    start = 1'b1; op = DIVU; dataA = 32'd100; dataB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = NOP;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 11) check_output("seqB busy before rst", {31'b0, busy}, 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("seqB busy after rst", {31'b0, busy}, 32'd0);
    check_output("seqB done after rst", {31'b0, done}, 32'd0);
    check_output("seqB hi after rst", hi, 32'd0);
    check_output("seqB lo after rst", lo, 32'd0);
    v = '{MULTU, 32'd3, 32'd4, 1'b0, 32'h0, 32'h0, 32'h0, 32'd12};
    apply_stimulus(v, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
